// File: rtl/matrix_operand_feeder_if.sv
//------------------------------------------------------------------------------
// matrix_operand_feeder_if : load/start/hold controls and operand stream bundle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface matrix_operand_feeder_if #(
    parameter int DW = 8
);
    logic          ld_en;
    logic          ld_sel;
    logic [3:0]    ld_addr;
    logic [DW-1:0] ld_data;
    logic          start;
    logic          hold;
    logic [DW-1:0] a_out;
    logic [DW-1:0] b_out;
    logic          op_valid;
    logic          op_last;
    logic [1:0]    res_row;
    logic [1:0]    res_col;
    logic          busy;
    logic          done;

    modport master (
        output ld_en, ld_sel, ld_addr, ld_data, start, hold,
        input  a_out, b_out, op_valid, op_last, res_row, res_col, busy, done
    );

    modport slave (
        input  ld_en, ld_sel, ld_addr, ld_data, start, hold,
        output a_out, b_out, op_valid, op_last, res_row, res_col, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/matrix_operand_feeder.sv
//------------------------------------------------------------------------------
// matrix_operand_feeder : streams the 27 (A[i][k], B[k][j]) pairs of a 3x3 product
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module matrix_operand_feeder #(
    parameter int DW = 8,
    parameter int N  = 3
) (
    input  wire logic                clk,
    input  wire logic                aclr,
    matrix_operand_feeder_if.slave   bus
);
    localparam logic [1:0] c_LAST     = 2'(N - 1);
    localparam logic [3:0] c_MAX_ADDR = 4'(N * N - 1);
    localparam logic [3:0] c_STRIDE   = 4'(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] a_mem_q [9];
    logic [DW-1:0] b_mem_q [9];
    logic [1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DW-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
    logic          op_valid_q, op_valid_d, op_last_q, op_last_d;
    logic [1:0]    res_row_q, res_row_d, res_col_q, res_col_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          wr_en;
    logic [3:0]    a_idx, b_idx;
    logic          final_in_flight;

    assign wr_en  = (state_q == ST_IDLE) && bus.ld_en && (bus.ld_addr <= c_MAX_ADDR);
    assign a_idx  = {2'b00, i_q} * c_STRIDE + {2'b00, k_q};
    assign b_idx  = {2'b00, k_q} * c_STRIDE + {2'b00, j_q};
    // The last term is detected from the registered outputs, so RUN lasts one cycle past its issue.
    assign final_in_flight = op_valid_q && op_last_q && (res_row_q == c_LAST) && (res_col_q == c_LAST);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int n = 0; n < 9; n++) begin
                a_mem_q[n] <= '0;
                b_mem_q[n] <= '0;
            end
        end else if (wr_en) begin
            if (bus.ld_sel) begin
                b_mem_q[bus.ld_addr] <= bus.ld_data;
            end else begin
                a_mem_q[bus.ld_addr] <= bus.ld_data;
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            a_out_q    <= '0;
            b_out_q    <= '0;
            op_valid_q <= 1'b0;
            op_last_q  <= 1'b0;
            res_row_q  <= '0;
            res_col_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            a_out_q    <= a_out_d;
            b_out_q    <= b_out_d;
            op_valid_q <= op_valid_d;
            op_last_q  <= op_last_d;
            res_row_q  <= res_row_d;
            res_col_q  <= res_col_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        a_out_d    = '0;
        b_out_d    = '0;
        op_valid_d = 1'b0;
        op_last_d  = 1'b0;
        res_row_d  = '0;
        res_col_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                if (final_in_flight) begin
                    state_d = ST_DONE;
                // Stalls are only legal before k=0 so a dot product is never split.
                end else if (!((k_q == 2'd0) && bus.hold)) begin
                    a_out_d    = a_mem_q[a_idx];
                    b_out_d    = b_mem_q[b_idx];
                    op_valid_d = 1'b1;
                    op_last_d  = (k_q == c_LAST);
                    res_row_d  = i_q;
                    res_col_d  = j_q;
                    if (k_q == c_LAST) begin
                        k_d = '0;
                        if (j_q == c_LAST) begin
                            j_d = '0;
                            i_d = (i_q == c_LAST) ? 2'd0 : i_q + 2'd1;
                        end else begin
                            j_d = j_q + 2'd1;
                        end
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    assign bus.a_out    = a_out_q;
    assign bus.b_out    = b_out_q;
    assign bus.op_valid = op_valid_q;
    assign bus.op_last  = op_last_q;
    assign bus.res_row  = res_row_q;
    assign bus.res_col  = res_col_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

`default_nettype wire
